// File: rtl/tx_sched.sv
// tx_sched -- transmit scheduler for the FPGA serial test.
//
// This block shares one UART transmitter between the pattern generator and
// the receive-echo path. It arbitrates round-robin between the two, runs the
// load/busy handshake with the transmitter and tracks the output column.
//
// Optional feature macro: TX_AUTO_WRAP_EN
//   defined   - a CR/LF pair is inserted when the column reaches COLUMNS.
//   undefined - the wrap states are not built. col still tracks and
//               saturates at COLUMNS.
//
// Parameters
//   COLUMNS  line width in printable characters (1..127)
//   TIMEOUT  cycles to wait for tx_busy to rise after a load (2..255)
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_pat_req      pattern generator has a character on i_pat_char
//   i_pat_char     pattern character, stable while i_pat_req=1
//   o_pat_ack      one-cycle pulse when i_pat_char is consumed
//   i_echo_req     echo path has a character on i_echo_char
//   i_echo_char    echo character, stable while i_echo_req=1
//   o_echo_ack     one-cycle pulse when i_echo_char is consumed
//   i_tx_busy      UART transmitter is shifting a character
//   o_tx_load      one-cycle pulse; the UART latches o_tx_data
//   o_tx_data      character to transmit, held until the next load
//   o_col          current output column, 0..COLUMNS
//   o_timeout_err  sticky: tx_busy never rose after a load
module tx_sched #(
  parameter int COLUMNS = 80,
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pat_req,
  input  logic [7:0] i_pat_char,
  output logic       o_pat_ack,
  input  logic       i_echo_req,
  input  logic [7:0] i_echo_char,
  output logic       o_echo_ack,
  input  logic       i_tx_busy,
  output logic       o_tx_load,
  output logic [7:0] o_tx_data,
  output logic [6:0] o_col,
  output logic       o_timeout_err
);

  localparam logic [6:0] COL_MAX = 7'(COLUMNS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BUSY = 3'd1,
    S_WAIT_DONE = 3'd2
`ifdef TX_AUTO_WRAP_EN
    ,
    S_WRAP_CR   = 3'd3,
    S_WRAP_LF   = 3'd4
`endif
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_tx_load, w_load;
  logic [7:0] r_tx_data, w_data;
  logic       r_pat_ack, w_pat_ack;
  logic       r_echo_ack, w_echo_ack;
  logic [6:0] r_col, w_col_nxt;
  logic       r_err, w_err_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  // 1 = echo received the most recent grant; reset to pattern so that
  // echo wins the first tie.
  logic       r_last_echo, w_last_echo_nxt;
`ifdef TX_AUTO_WRAP_EN
  // Set while the auto CR is in flight so WAIT_DONE continues with the LF.
  logic       r_wrap_cr, w_wrap_cr_nxt;
`endif

  logic       w_gnt_echo, w_gnt_pat;

  // Round-robin: a lone request wins, a tie goes to whoever did not win last.
  assign w_gnt_echo = i_echo_req & (~i_pat_req  |  ~r_last_echo);
  assign w_gnt_pat  = i_pat_req  & (~i_echo_req |   r_last_echo);

  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_data          = r_tx_data;
    w_pat_ack       = 1'b0;
    w_echo_ack      = 1'b0;
    w_err_nxt       = r_err;
    w_cnt_nxt       = r_cnt;
    w_last_echo_nxt = r_last_echo;
`ifdef TX_AUTO_WRAP_EN
    w_wrap_cr_nxt   = r_wrap_cr;
`endif
    case (r_state)
      S_IDLE: begin
        if (!i_tx_busy) begin
`ifdef TX_AUTO_WRAP_EN
          // A due wrap pre-empts both requesters; they simply keep waiting.
          if (r_col == COL_MAX) w_state_nxt = S_WRAP_CR;
          else
`endif
          if (w_gnt_echo) begin
            w_load          = 1'b1;
            w_data          = i_echo_char;
            w_echo_ack      = 1'b1;
            w_last_echo_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_WAIT_BUSY;
          end else if (w_gnt_pat) begin
            w_load          = 1'b1;
            w_data          = i_pat_char;
            w_pat_ack       = 1'b1;
            w_last_echo_nxt = 1'b0;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_WAIT_BUSY;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == TO_LAST) begin
          // Transmitter never answered: flag it, abandon any wrap in flight.
          w_err_nxt     = 1'b1;
          w_cnt_nxt     = '0;
`ifdef TX_AUTO_WRAP_EN
          w_wrap_cr_nxt = 1'b0;
`endif
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
`ifdef TX_AUTO_WRAP_EN
          if (r_wrap_cr) begin
            w_wrap_cr_nxt = 1'b0;
            w_state_nxt   = S_WRAP_LF;
          end else
`endif
          w_state_nxt = S_IDLE;
        end
      end
`ifdef TX_AUTO_WRAP_EN
      S_WRAP_CR: begin
        w_load        = 1'b1;
        w_data        = CH_CR;
        w_wrap_cr_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_WAIT_BUSY;
      end
      S_WRAP_LF: begin
        w_load      = 1'b1;
        w_data      = CH_LF;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Column follows whatever is loaded, including inserted CR/LF.
  always_comb begin
    w_col_nxt = r_col;
    if (w_load) begin
      if (w_data >= 8'h20 && w_data <= 8'h7E) begin
        if (r_col < COL_MAX) w_col_nxt = r_col + 7'd1;
      end else if (w_data == CH_CR) begin
        w_col_nxt = '0;
      end else if (w_data == CH_BS && r_col != '0) begin
        w_col_nxt = r_col - 7'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_tx_load   <= 1'b0;
      r_tx_data   <= 8'h00;
      r_pat_ack   <= 1'b0;
      r_echo_ack  <= 1'b0;
      r_col       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_last_echo <= 1'b0;
`ifdef TX_AUTO_WRAP_EN
      r_wrap_cr   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_tx_load   <= w_load;
      r_tx_data   <= w_data;
      r_pat_ack   <= w_pat_ack;
      r_echo_ack  <= w_echo_ack;
      r_col       <= w_col_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_echo <= w_last_echo_nxt;
`ifdef TX_AUTO_WRAP_EN
      r_wrap_cr   <= w_wrap_cr_nxt;
`endif
    end
  end

  assign o_tx_load     = r_tx_load;
  assign o_tx_data     = r_tx_data;
  assign o_pat_ack     = r_pat_ack;
  assign o_echo_ack    = r_echo_ack;
  assign o_col         = r_col;
  assign o_timeout_err = r_err;

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched with COLUMNS=4, TIMEOUT=16. A small UART model raises
// busy one cycle after each load for busy_len cycles (disabled by uart_on=0).
module tb_tx_sched;

  localparam int COLS = 4;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pat_req = 1'b0, echo_req = 1'b0;
  logic [7:0] pat_char = 8'h00, echo_char = 8'h00;
  logic       busy;
  logic       o_pat_ack, o_echo_ack, o_tx_load, o_timeout_err;
  logic [7:0] o_tx_data;
  logic [6:0] o_col;

  int total = 0;
  int bad   = 0;
  int busy_len = 3;
  bit uart_on  = 1'b1;
  int bcnt;

  always #5 clk = ~clk;

  tx_sched #(.COLUMNS(COLS), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pat_req(pat_req), .i_pat_char(pat_char), .o_pat_ack(o_pat_ack),
    .i_echo_req(echo_req), .i_echo_char(echo_char), .o_echo_ack(o_echo_ack),
    .i_tx_busy(busy), .o_tx_load(o_tx_load), .o_tx_data(o_tx_data),
    .o_col(o_col), .o_timeout_err(o_timeout_err)
  );

  // UART model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy <= 1'b0;
    end else if (o_tx_load && uart_on) begin
      busy <= 1'b1;
      bcnt <= busy_len;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    pat_req = 1'b0; echo_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_load(output bit ok, output int n);
    ok = 1'b0; n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (o_tx_load) ok = 1'b1;
    end
  endtask

  // Pattern requester: advances its character on every ack and stops
  // requesting after nchar acks. Records nload loads.
  logic [7:0] ld_data[16];
  bit         ld_ack[16];
  int         ld_col[16];
  task automatic pat_stream(input int nchar, input int nload, input logic [7:0] c0);
    int sent = 0, got = 0, guard = 0;
    pat_char = c0; pat_req = 1'b1;
    while (got < nload && guard < 400) begin
      @(negedge clk);
      guard++;
      if (o_tx_load) begin
        ld_data[got] = o_tx_data; ld_ack[got] = o_pat_ack; ld_col[got] = int'(o_col);
        got++;
        if (o_pat_ack) begin
          sent++;
          pat_char = c0 + 8'(sent);
          if (sent >= nchar) pat_req = 1'b0;
        end
      end
    end
    pat_req = 1'b0;
    chk("stream_load_count", got, nload);
  endtask

  typedef struct {
    bit         echo;
    logic [7:0] ch;
    logic [6:0] col;
  } vec_t;
  vec_t tbl[10];

  initial begin
    bit ok;
    int n, seen;
    logic [7:0] xd[7];
    bit         xa[7];
    int         xc[7];
    int         nl;

    tbl[0] = '{1'b0, 8'h41, 7'd1};
    tbl[1] = '{1'b1, 8'h20, 7'd2};
    tbl[2] = '{1'b1, 8'h0D, 7'd0};  // own CR at col 2
    tbl[3] = '{1'b1, 8'h08, 7'd0};  // BS at col 0 stays 0
    tbl[4] = '{1'b0, 8'h7E, 7'd1};
    tbl[5] = '{1'b0, 8'h0A, 7'd1};  // LF leaves col
    tbl[6] = '{1'b1, 8'h7F, 7'd1};  // DEL not printable
    tbl[7] = '{1'b0, 8'h08, 7'd0};
    tbl[8] = '{1'b1, 8'h1F, 7'd0};
    tbl[9] = '{1'b0, 8'h21, 7'd1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_load", o_tx_load, 0);
    chk("rst_data", o_tx_data, 8'h00);
    chk("rst_pack", o_pat_ack, 0);
    chk("rst_eack", o_echo_ack, 0);
    chk("rst_col", o_col, 0);
    chk("rst_err", o_timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single pattern 'A' with 10-cycle busy, then spacing to the next grant
    busy_len = 10;
    pat_char = 8'h41; pat_req = 1'b1;
    wait_load(ok, n);
    chk("a_seen", ok, 1);
    chk("a_data", o_tx_data, 8'h41);
    chk("a_pack", o_pat_ack, 1);
    chk("a_eack", o_echo_ack, 0);
    chk("a_col", o_col, 1);
    pat_char = 8'h42;
    @(negedge clk);
    chk("a_ack_width", o_pat_ack, 0);
    wait_load(ok, n);
    chk("b_seen", ok, 1);
    chk("b_gap_over_busy", (n + 1) > 10, 1);
    chk("b_data", o_tx_data, 8'h42);
    chk("b_col", o_col, 2);
    pat_req = 1'b0;

    // column update table
    busy_len = 3;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].echo) begin echo_char = tbl[i].ch; echo_req = 1'b1; end
      else begin pat_char = tbl[i].ch; pat_req = 1'b1; end
      wait_load(ok, n);
      chk($sformatf("v%0d_seen", i), ok, 1);
      chk($sformatf("v%0d_data", i), o_tx_data, tbl[i].ch);
      chk($sformatf("v%0d_eack", i), o_echo_ack, tbl[i].echo);
      chk($sformatf("v%0d_pack", i), o_pat_ack, !tbl[i].echo);
      chk($sformatf("v%0d_col", i), o_col, tbl[i].col);
      pat_req = 1'b0; echo_req = 1'b0;
    end

    // both requesting continuously: E,P,E,P starting with echo
    do_reset();
    echo_char = 8'h45; pat_char = 8'h50;
    echo_req = 1'b1; pat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_load(ok, n);
      chk($sformatf("rr%0d_seen", i), ok, 1);
      if (i > 0) chk($sformatf("rr%0d_gap3", i), n >= 3, 1);
      chk($sformatf("rr%0d_data", i), o_tx_data, (i % 2 == 0) ? 8'h45 : 8'h50);
      chk($sformatf("rr%0d_eack", i), o_echo_ack, (i % 2 == 0));
      chk($sformatf("rr%0d_pack", i), o_pat_ack, (i % 2 == 1));
    end
    echo_req = 1'b0; pat_req = 1'b0;
    chk("rr_col_sat", o_col, 4);

    // line width: wrap insertion or saturation
    do_reset();
`ifdef TX_AUTO_WRAP_EN
    nl = 7;
    xd = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A, 8'h24};
    xa = '{1, 1, 1, 1, 0, 0, 1};
    xc = '{1, 2, 3, 4, 0, 0, 1};
`else
    nl = 5;
    xd = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h00};
    xa = '{1, 1, 1, 1, 1, 0, 0};
    xc = '{1, 2, 3, 4, 4, 0, 0};
`endif
    pat_stream(5, nl, 8'h20);
    for (int i = 0; i < nl; i++) begin
      chk($sformatf("w%0d_data", i), ld_data[i], xd[i]);
      chk($sformatf("w%0d_ack", i), ld_ack[i], xa[i]);
      chk($sformatf("w%0d_col", i), ld_col[i], xc[i]);
    end

    // transmitter never goes busy
    do_reset();
    uart_on = 1'b0;
    pat_char = 8'h41; pat_req = 1'b1;
    wait_load(ok, n);
    chk("to_first_seen", ok, 1);
    pat_req = 1'b0;
    repeat (TO - 2) @(negedge clk);
    chk("to_not_early", o_timeout_err, 0);
    n = 0;
    while (!o_timeout_err && n < 6) begin @(negedge clk); n++; end
    chk("to_err_set", o_timeout_err, 1);
    uart_on = 1'b1;
    pat_char = 8'h42; pat_req = 1'b1;
    wait_load(ok, n);
    chk("to_next_seen", ok, 1);
    chk("to_next_data", o_tx_data, 8'h42);
    chk("to_next_pack", o_pat_ack, 1);
    pat_req = 1'b0;
    @(negedge clk);
    chk("to_err_sticky", o_timeout_err, 1);

    // reset in the middle of WAIT_DONE (of the auto CR when wrapping)
    do_reset();
    busy_len = 10;
`ifdef TX_AUTO_WRAP_EN
    pat_stream(4, 5, 8'h41);
    chk("rm_cr_data", ld_data[4], 8'h0D);
    chk("rm_cr_noack", ld_ack[4], 0);
`else
    pat_stream(4, 4, 8'h41);
    chk("rm_last_data", ld_data[3], 8'h44);
`endif
    repeat (3) @(negedge clk);
    chk("rm_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_load", o_tx_load, 0);
    chk("rm_data", o_tx_data, 8'h00);
    chk("rm_pack", o_pat_ack, 0);
    chk("rm_eack", o_echo_ack, 0);
    chk("rm_col", o_col, 0);
    chk("rm_err", o_timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_tx_load) seen++;
    end
    chk("rm_no_load_after", seen, 0);
    chk("rm_col_after", o_col, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
